gsensor_ctrl: RTL and testbench

- Transaction sequencer directly upstream of the SPI serdes in the gsensor path; drives its start/data_tx and consumes its done/data_rx.
- After reset, writes a fixed ADXL345 configuration (DATA_FORMAT, BW_RATE, then POWER_CTL).
- Then periodically reads the six data registers 0x32..0x37 and presents signed 16-bit X/Y/Z samples with a one-cycle valid strobe.

---
 rtl/gsensor_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_gsensor_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsensor_ctrl.sv
// gsensor_ctrl: transaction sequencer in front of the SPI serdes that talks
// to an ADXL345 accelerometer.
//  - After reset it writes DATA_FORMAT, BW_RATE and POWER_CTL, in that order.
//  - It then reads the six data registers 0x32..0x37 once per sample period
//    and presents signed 16-bit X/Y/Z samples with a one-cycle valid strobe.
// Build option: define GSENSOR_DEVID_CHECK_EN to check the device ID
// (register 0x00 must read 0xE5) before any configuration write. Without it
// the ID states are not built and dev_err is tied low.
module gsensor_ctrl #(
  parameter int         SAMPLE_DIV      = 20000,  // spi_clk cycles per sample, >= 2
  parameter logic [7:0] DATA_FORMAT_VAL = 8'h0B,  // written to 0x31
  parameter logic [7:0] BW_RATE_VAL     = 8'h0A,  // written to 0x2C
  parameter logic [7:0] POWER_CTL_VAL   = 8'h08   // written to 0x2D
) (
  input  logic        reset_n,
  input  logic        spi_clk,
  output logic        start,
  output logic [15:0] data_tx,
  input  logic        done,
  input  logic [7:0]  data_rx,
  output logic        init_done,
  output logic [15:0] x_data,
  output logic [15:0] y_data,
  output logic [15:0] z_data,
  output logic        data_valid,
  output logic        dev_err
);

  // Register map addresses used by the sequencer.
  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [7:0] DEVID_EXPECTED   = 8'hE5;

  // Period timer width; at least one bit even for the smallest divider.
  localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  // Sequencer states. The ID-check states only exist when the check is built.
  typedef enum logic [3:0] {
    ST_CFG_ISSUE,
    ST_CFG_WAIT,
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_UPDATE
`ifdef GSENSOR_DEVID_CHECK_EN
    ,
    ST_ID_ISSUE,
    ST_ID_WAIT,
    ST_ERR
`endif
  } state_t;

`ifdef GSENSOR_DEVID_CHECK_EN
  localparam state_t ST_RESET = ST_ID_ISSUE;
`else
  localparam state_t ST_RESET = ST_CFG_ISSUE;
`endif

  state_t           state_reg;
  logic [1:0]       cfg_idx_reg;
  logic [2:0]       rd_idx_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             tick_pending_reg;
  logic [7:0]       shadow_reg [6];

  logic tick;
  logic tick_clear;
  logic shadow_we;

  // Write command: R/W=0, MB=0, 6-bit address, data byte.
  function automatic logic [15:0] wr_word(input logic [5:0] addr, input logic [7:0] data);
    return {1'b0, 1'b0, addr, data};
  endfunction

  // Read command: R/W=1, MB=0, 6-bit address, don't-care byte sent as 0.
  function automatic logic [15:0] rd_word(input logic [5:0] addr);
    return {1'b1, 1'b0, addr, 8'h00};
  endfunction

  // Configuration table, indexed by cfg_idx.
  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = wr_word(ADDR_DATA_FORMAT, DATA_FORMAT_VAL);
      2'd1:    w = wr_word(ADDR_BW_RATE, BW_RATE_VAL);
      default: w = wr_word(ADDR_POWER_CTL, POWER_CTL_VAL);
    endcase
    return w;
  endfunction

  // Timer wrap and pending-flag handshake with the sequencer.
  assign tick       = init_done && (cnt_reg == CNT_LAST);
  assign tick_clear = (state_reg == ST_IDLE) && tick_pending_reg;
  assign shadow_we  = (state_reg == ST_RD_WAIT) && done;

  // Sample period timer; a fresh tick re-arms pending even when it is being consumed.
  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg          <= '0;
      tick_pending_reg <= 1'b0;
    end else begin
      if (!init_done || tick) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      tick_pending_reg <= (tick_pending_reg && !tick_clear) || tick;
    end
  end

  // Shadow bytes of the burst in flight; outputs only see them after all six arrive.
  always_ff @(posedge spi_clk) begin
    if (shadow_we) begin
      shadow_reg[rd_idx_reg] <= data_rx;
    end
  end

  // Main sequencer with registered command/strobe/sample outputs.
  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_RESET;
      cfg_idx_reg <= 2'd0;
      rd_idx_reg  <= 3'd0;
      start       <= 1'b0;
      data_tx     <= 16'h0000;
      init_done   <= 1'b0;
      x_data      <= 16'h0000;
      y_data      <= 16'h0000;
      z_data      <= 16'h0000;
      data_valid  <= 1'b0;
`ifdef GSENSOR_DEVID_CHECK_EN
      dev_err     <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; data_tx keeps the last command until reissued.
      start      <= 1'b0;
      data_valid <= 1'b0;
      case (state_reg)
`ifdef GSENSOR_DEVID_CHECK_EN
        ST_ID_ISSUE: begin
          start     <= 1'b1;
          data_tx   <= rd_word(ADDR_DEVID);
          state_reg <= ST_ID_WAIT;
        end
        ST_ID_WAIT: begin
          if (done) begin
            if (data_rx == DEVID_EXPECTED) begin
              state_reg <= ST_CFG_ISSUE;
            end else begin
              dev_err   <= 1'b1;
              state_reg <= ST_ERR;
            end
          end
        end
        ST_ERR: begin
          // Parked until reset; no more traffic to a device we do not recognise.
          state_reg <= ST_ERR;
        end
`endif
        ST_CFG_ISSUE: begin
          start     <= 1'b1;
          data_tx   <= cfg_word(cfg_idx_reg);
          state_reg <= ST_CFG_WAIT;
        end
        ST_CFG_WAIT: begin
          if (done) begin
            cfg_idx_reg <= cfg_idx_reg + 2'd1;
            if (cfg_idx_reg == 2'd2) begin
              init_done <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_CFG_ISSUE;
            end
          end
        end
        ST_IDLE: begin
          if (tick_pending_reg) begin
            rd_idx_reg <= 3'd0;
            state_reg  <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          start     <= 1'b1;
          data_tx   <= rd_word(ADDR_DATAX0 + {3'b000, rd_idx_reg});
          state_reg <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (done) begin
            if (rd_idx_reg == 3'd5) begin
              state_reg <= ST_UPDATE;
            end else begin
              rd_idx_reg <= rd_idx_reg + 3'd1;
              state_reg  <= ST_RD_ISSUE;
            end
          end
        end
        ST_UPDATE: begin
          // All three axes change together, from one complete burst.
          x_data     <= {shadow_reg[1], shadow_reg[0]};
          y_data     <= {shadow_reg[3], shadow_reg[2]};
          z_data     <= {shadow_reg[5], shadow_reg[4]};
          data_valid <= 1'b1;
          state_reg  <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_RESET;
        end
      endcase
    end
  end

`ifndef GSENSOR_DEVID_CHECK_EN
  // Without the ID check there is nothing that can flag a device error.
  assign dev_err = 1'b0;
`endif

endmodule

// File: tb/tb_gsensor_ctrl.sv
// tb_gsensor_ctrl: directed bench for gsensor_ctrl with a behavioural serdes
// model (fixed done latency per transaction) and a protocol monitor.
module tb_gsensor_ctrl;

  localparam int DIV = 64;

  logic        reset_n;
  logic        spi_clk;
  logic        start;
  logic [15:0] data_tx;
  logic        done;
  logic [7:0]  data_rx;
  logic        init_done;
  logic [15:0] x_data;
  logic [15:0] y_data;
  logic [15:0] z_data;
  logic        data_valid;
  logic        dev_err;

  gsensor_ctrl #(
    .SAMPLE_DIV      (DIV),
    .DATA_FORMAT_VAL (8'h0B),
    .BW_RATE_VAL     (8'h0A),
    .POWER_CTL_VAL   (8'h08)
  ) dut (
    .reset_n    (reset_n),
    .spi_clk    (spi_clk),
    .start      (start),
    .data_tx    (data_tx),
    .done       (done),
    .data_rx    (data_rx),
    .init_done  (init_done),
    .x_data     (x_data),
    .y_data     (y_data),
    .z_data     (z_data),
    .data_valid (data_valid),
    .dev_err    (dev_err)
  );

  int total = 0;
  int bad   = 0;

  // One comparison: count it, report a mismatch with both values.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  int cyc = 0;
  always @(posedge spi_clk) cyc++;

  // ---------------- serdes model ----------------
  int          lat = 17;
  logic [7:0]  id_val = 8'hE5;
  bit          tag_mode = 1'b0;
  bit          burst_tagged = 1'b0;
  int          burst_no = 0;
  logic [15:0] cmd;
  int          mcnt;
  bit          busy;

  // Read data: fixed sample set, or burst-tagged bytes {burst, addr nibble}.
  function automatic logic [7:0] resp(input logic [15:0] c);
    logic [5:0] a;
    logic [7:0] b;
    a = c[13:8];
    b = 8'h00;
    if (a == 6'h00) b = id_val;
    else if (burst_tagged) b = {4'(burst_no), a[3:0]};
    else begin
      case (a)
        6'h32: b = 8'h34;
        6'h33: b = 8'h12;
        6'h34: b = 8'hFE;
        6'h35: b = 8'hFF;
        6'h36: b = 8'h00;
        6'h37: b = 8'h80;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  always @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      data_rx <= 8'h00;
      mcnt    <= 0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cmd  <= data_tx;
        mcnt <= lat;
        if (data_tx == 16'hB200) begin
          burst_no     <= burst_no + 1;
          burst_tagged <= tag_mode;
        end
      end else if (busy) begin
        mcnt <= mcnt - 1;
        if (mcnt == 2) begin
          done    <= 1'b1;
          busy    <= 1'b0;
          data_rx <= resp(cmd);
        end
      end
    end
  end

  // ---------------- protocol monitor ----------------
  logic [15:0] starts[$];
  int          done_cyc[$];
  int          n_start, n_done, n_valid, n_b200;
  int          proto_err = 0, partial_err = 0, mix_err = 0;
  int          init_rise_cyc = -1, last_valid_cyc = -1, last_gap = -1;
  logic        start_d, init_d;
  logic [15:0] tx_held, xp, yp, zp;
  logic [3:0]  bn;

  initial begin
    n_valid = 0;
    n_b200  = 0;
  end

  always @(negedge spi_clk) begin
    if (reset_n) begin
      if (start && done) proto_err++;
      if (start && start_d) proto_err++;
      if (start && n_start != n_done) proto_err++;
      if (done && n_start != n_done + 1) proto_err++;
      if (!start && n_start != n_done && data_tx != tx_held) proto_err++;
      if (!data_valid && (x_data != xp || y_data != yp || z_data != zp)) partial_err++;
      if (start) begin
        n_start++;
        tx_held = data_tx;
        starts.push_back(data_tx);
        if (data_tx == 16'hB200) begin
          n_b200++;
          if (last_valid_cyc >= 0) last_gap = cyc - last_valid_cyc;
        end
      end
      if (done) begin
        n_done++;
        done_cyc.push_back(cyc);
      end
      if (init_done && !init_d) init_rise_cyc = cyc;
      if (data_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        if (burst_tagged) begin
          bn = x_data[15:12];
          if (x_data != {bn, 4'h3, bn, 4'h2} || y_data != {bn, 4'h5, bn, 4'h4} ||
              z_data != {bn, 4'h7, bn, 4'h6} || bn != 4'(burst_no)) mix_err++;
        end
      end
      start_d = start;
      init_d  = init_done;
    end else begin
      n_start = 0;
      n_done  = 0;
      start_d = 1'b0;
      init_d  = 1'b0;
    end
    xp = x_data;
    yp = y_data;
    zp = z_data;
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int base, k, sz, t0, t1, nv, d;
    reset_n = 1'b0;
`ifdef GSENSOR_DEVID_CHECK_EN
    base = 1;
`else
    base = 0;
`endif
    repeat (3) @(negedge spi_clk);
    check_eq("rst_start", start, 0);
    check_eq("rst_data_tx", data_tx, 0);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_x", x_data, 0);
    check_eq("rst_y", y_data, 0);
    check_eq("rst_z", z_data, 0);
    check_eq("rst_valid", data_valid, 0);
    check_eq("rst_dev_err", dev_err, 0);

    // Configuration writes.
    reset_n = 1'b1;
    k = 0;
    while (!init_done && k < 500) begin @(negedge spi_clk); k++; end
    check_eq("tmo_cfg", k >= 500, 0);
    @(negedge spi_clk);
    if (starts.size() >= base + 3) begin
`ifdef GSENSOR_DEVID_CHECK_EN
      check_eq("id_read", starts[0], 16'h8000);
`endif
      check_eq("cfg0", starts[base], 16'h310B);
      check_eq("cfg1", starts[base+1], 16'h2C0A);
      check_eq("cfg2", starts[base+2], 16'h2D08);
    end else check_eq("cfg_count", starts.size(), base + 3);
    if (done_cyc.size() >= base + 3)
      check_eq("init_rise", init_rise_cyc, done_cyc[base+2] + 1);
    else check_eq("done_count", done_cyc.size(), base + 3);

    // First burst with fixed sample bytes.
    k = 0;
    while (!data_valid && k < 1000) begin @(negedge spi_clk); k++; end
    check_eq("tmo_burst", k >= 1000, 0);
    check_eq("x0", x_data, 16'h1234);
    check_eq("y0", y_data, 16'hFFFE);
    check_eq("z0", z_data, 16'h8000);
    if (starts.size() >= base + 9) begin
      for (int i = 0; i < 6; i++)
        check_eq($sformatf("rd%0d", i), starts[base+3+i], 16'hB200 + 16'(i * 256));
    end else check_eq("rd_count", starts.size(), base + 9);
    tag_mode = 1'b1;
    @(negedge spi_clk);
    check_eq("valid_1cyc", data_valid, 0);
    repeat (5) @(negedge spi_clk);
    check_eq("x_hold", x_data, 16'h1234);

    // Slow serdes: bursts longer than the period run back to back.
    lat = 20;
    repeat (1500) @(negedge spi_clk);
    d = n_b200 - n_valid;
    check_eq("burst_vs_valid", (d == 0 || d == 1), 1);
    check_eq("b2b_gap", last_gap, 2);

    // Fast serdes: pending collapsed to one, so the period settles to DIV.
    lat = 2;
    nv = 0;
    t0 = 0;
    t1 = 0;
    k = 0;
    while (nv < 6 && k < 2000) begin
      @(negedge spi_clk);
      k++;
      if (data_valid) begin
        nv++;
        t0 = t1;
        t1 = cyc;
      end
    end
    check_eq("tmo_fast", k >= 2000, 0);
    check_eq("period", t1 - t0, DIV);

    // Reset in the middle of the third read of a burst.
    lat = 17;
    k = 0;
    while (!(start && data_tx == 16'hB400) && k < 1000) begin @(negedge spi_clk); k++; end
    check_eq("tmo_rd3", k >= 1000, 0);
    repeat (4) @(negedge spi_clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_x", x_data, 0);
    check_eq("arst_y", y_data, 0);
    check_eq("arst_z", z_data, 0);
    check_eq("arst_data_tx", data_tx, 0);
    check_eq("arst_init_done", init_done, 0);
    check_eq("arst_dev_err", dev_err, 0);
    repeat (3) @(negedge spi_clk);
    sz = starts.size();
    reset_n = 1'b1;
    k = 0;
    while (starts.size() <= sz && k < 100) begin @(negedge spi_clk); k++; end
    check_eq("tmo_restart", k >= 100, 0);
    if (starts.size() > sz) begin
`ifdef GSENSOR_DEVID_CHECK_EN
      check_eq("restart_word", starts[sz], 16'h8000);
`else
      check_eq("restart_word", starts[sz], 16'h310B);
`endif
    end

`ifdef GSENSOR_DEVID_CHECK_EN
    // Wrong device ID: park in error, no further traffic.
    reset_n = 1'b0;
    id_val  = 8'hE4;
    repeat (3) @(negedge spi_clk);
    sz = starts.size();
    reset_n = 1'b1;
    repeat (1000) @(negedge spi_clk);
    check_eq("id_bad_dev_err", dev_err, 1);
    check_eq("id_bad_init", init_done, 0);
    check_eq("id_bad_starts", starts.size() - sz, 1);
`endif

    check_eq("protocol", proto_err, 0);
    check_eq("partial", partial_err, 0);
    check_eq("mixed", mix_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
